// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control unit.
// Steps each instruction through fetch/decode/execute/memory/writeback from
// the opcode and drives datapath selects, write strobes and ALUOp for ALUctrl.
module mc_ctrl_fsm #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             Branch,
    output logic             pc_en,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [2:0]       ALUOp,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC    = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    logic [3:0] cur;
    logic [3:0] nxt;
    logic       retire;
    logic       op_legal;

    assign state = cur;

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= S_FETCH;
        else        cur <= nxt;
    end

    // Next-state selection; memory states hold until the handshake completes.
    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_R:         nxt = S_EXEC;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_ADDI:      nxt = S_ADDIEX;
                    OP_J:         nxt = S_JUMP;
                    default:      nxt = S_FETCH;
                endcase
            end
            // IR is stable from decode onward, so opcode is still valid here.
            S_MEMADR: nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   nxt = S_RTYPEWB;
            S_ADDIEX: nxt = S_ADDIWB;
            default:  nxt = S_FETCH;
        endcase
    end

    // Opcode support check, used only for the decode-time illegal pulse.
    always_comb begin
        case (opcode)
            OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_legal = 1'b1;
            default:                                   op_legal = 1'b0;
        endcase
    end

    // Moore output decode; strobes are forced low while reset is held.
    always_comb begin
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSource   = 2'b00;
        ALUOp      = ALU_ADD;
        illegal_op = 1'b0;
        case (cur)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = !op_legal;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            S_RTYPEWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALU_SUB;
                PCSource = 2'b01;
                Branch   = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            PCWrite    = 1'b0;
            Branch     = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            illegal_op = 1'b0;
        end
        pc_en = PCWrite | (Branch & zero);
    end

    // An instruction retires on the edge that leaves its final state.
    always_comb begin
        case (cur)
            S_MEMWB, S_RTYPEWB, S_BRANCH, S_ADDIWB, S_JUMP: retire = 1'b1;
            S_MEMWR: retire = mem_ready;
            default: retire = 1'b0;
        endcase
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      instr_count <= '0;
        else if (retire) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: the stimulus side walks whole instructions
// (with planned memory stalls) and queues the per-cycle expectation; a monitor
// pops one entry per cycle and compares state, control outputs and count.
module tb_mc_ctrl_fsm;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             PCWrite, Branch, pc_en, IorD, MemRead, MemWrite, IRWrite;
    logic             RegDst, MemtoReg, RegWrite, ALUSrcA, illegal_op;
    logic [1:0]       ALUSrcB, PCSource;
    logic [2:0]       ALUOp;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    mc_ctrl_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .Branch(Branch), .pc_en(pc_en), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALUOp(ALUOp), .illegal_op(illegal_op), .state(state),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, br, pce, iord, mrd, mwr, irw, rdst, m2r, rw, srca;
        logic [1:0] srcb, pcsrc;
        logic [2:0] aluop;
        logic       ill;
    } ctl_t;

    typedef struct {
        int               st;
        ctl_t             c;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             q[$];
    int               n_chk = 0;
    int               n_pass = 0;
    bit               mon_en = 1'b0;
    logic [CNT_W-1:0] exp_cnt = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b000010 || op == 6'b000100 ||
               op == 6'b001000 || op == 6'b100011 || op == 6'b101011;
    endfunction

    // Control outputs each state presents, taken from the state table.
    function automatic ctl_t spec_ctl(input int st, input logic mr, input logic z, input bit leg);
        ctl_t c;
        c = '0;
        case (st)
            0:  begin c.mrd = 1; c.srcb = 2'b01; c.irw = mr; c.pcw = mr; end
            1:  begin c.srcb = 2'b11; c.ill = !leg; end
            2:  begin c.srca = 1; c.srcb = 2'b10; end
            3:  begin c.mrd = 1; c.iord = 1; end
            4:  begin c.m2r = 1; c.rw = 1; end
            5:  begin c.mwr = 1; c.iord = 1; end
            6:  begin c.srca = 1; c.aluop = 3'b010; end
            7:  begin c.rdst = 1; c.rw = 1; end
            8:  begin c.srca = 1; c.aluop = 3'b001; c.pcsrc = 2'b01; c.br = 1; end
            9:  begin c.srca = 1; c.srcb = 2'b10; end
            10: c.rw = 1;
            11: begin c.pcsrc = 2'b10; c.pcw = 1; end
            default: ;
        endcase
        c.pce = c.pcw | (c.br & z);
        return c;
    endfunction

    function automatic ctl_t dut_ctl();
        ctl_t c;
        c = {PCWrite, Branch, pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst,
             MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal_op};
        return c;
    endfunction

    // One clock of stimulus: drive inputs, queue what this cycle must show.
    task automatic step(input int st, input logic mr, input bit leg);
        exp_t e;
        logic z;
        z = 1'($urandom_range(0, 1));
        mem_ready = mr;
        zero = z;
        e.st = st;
        e.c = spec_ctl(st, mr, z, leg);
        e.cnt = exp_cnt;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Walk one instruction through its phase list; fst/mst are stall cycles.
    task automatic run_instr(input logic [5:0] op, input int fst, input int mst);
        bit leg;
        leg = is_legal(op);
        opcode = op;
        repeat (fst) step(0, 1'b0, leg);
        step(0, 1'b1, leg);
        step(1, rnd(), leg);
        case (op)
            6'b100011: begin
                step(2, rnd(), leg);
                repeat (mst) step(3, 1'b0, leg);
                step(3, 1'b1, leg);
                step(4, rnd(), leg);
            end
            6'b101011: begin
                step(2, rnd(), leg);
                repeat (mst) step(5, 1'b0, leg);
                step(5, 1'b1, leg);
            end
            6'b000000: begin step(6, rnd(), leg); step(7, rnd(), leg); end
            6'b000100: step(8, rnd(), leg);
            6'b001000: begin step(9, rnd(), leg); step(10, rnd(), leg); end
            6'b000010: step(11, rnd(), leg);
            default: ;
        endcase
        if (leg) exp_cnt = exp_cnt + 1'b1;
    endtask

    // Monitor: one queued expectation per clock while checking is enabled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (q.size() == 0) begin
                    chk("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("state", 32'(state), 32'(e.st));
                    chk("ctl", 32'(dut_ctl()), 32'(e.c));
                    chk("instr_count", 32'(instr_count), 32'(e.cnt));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_t  rc;
        logic [5:0] op;
        logic [5:0] pool [6];
        pool[0] = 6'b100011; pool[1] = 6'b101011; pool[2] = 6'b000000;
        pool[3] = 6'b000100; pool[4] = 6'b001000; pool[5] = 6'b000010;

        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = 6'b0;
        rc = spec_ctl(0, 1'b1, 1'b0, 1'b1);
        rc.pcw = 0; rc.irw = 0; rc.mrd = 0; rc.pce = 0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_state", 32'(state), 32'd0);
            chk("reset_count", 32'(instr_count), 32'd0);
            chk("reset_ctl", 32'(dut_ctl()), 32'(rc));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        run_instr(6'b000000, 0, 0);   // R-type
        run_instr(6'b100011, 0, 2);   // lw, two MEMRD stalls
        run_instr(6'b000100, 0, 0);   // beq (zero random per cycle)
        run_instr(6'b000100, 1, 0);
        run_instr(6'b111111, 0, 0);   // illegal
        run_instr(6'b000010, 0, 0);   // j
        run_instr(6'b101011, 2, 3);   // sw with stalls
        repeat (16) run_instr(6'b001000, 0, 0);  // wrap the 4-bit counter
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom_range(0, 63)); while (is_legal(op));
            end else begin
                op = pool[$urandom_range(0, 5)];
            end
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
        end
        mon_en = 1'b0;
        chk("queue_drained", 32'(q.size()), 32'd0);

        // Reset while a store is waiting on memory.
        opcode = 6'b101011; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        #2;
        chk("memwr_state", 32'(state), 32'd5);
        chk("memwr_strobe", 32'(MemWrite), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_memwrite", 32'(MemWrite), 32'd0);
        chk("midrst_count", 32'(instr_count), 32'd0);
        chk("midrst_memread", 32'(MemRead), 32'd0);
        #5;
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle MIPS main control unit; the producer side of the ALUOp interface consumed by ALUctrl.
- Sequences each instruction through fetch, decode, execute, memory and writeback states from the 6-bit opcode.
- Drives the datapath mux selects and write strobes, and drives ALUOp using the ALUctrl encoding:
  - 000: add
  - 001: subtract
  - 010: use funct field
- Sits between the instruction register / memory interface and the datapath.

Parameters:
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  instr[31:26] from instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory handshake; access completes in a cycle where it is high
PCWrite  output  1  unconditional PC write
Branch  output  1  conditional PC write (beq)
pc_en  output  1  PCWrite | (Branch & zero)
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
RegDst  output  1  0=rt, 1=rd
MemtoReg  output  1  0=ALUOut, 1=MDR
RegWrite  output  1  register file write
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
PCSource  output  2  00=ALU, 01=ALUOut, 10=jump target
ALUOp  output  3  to ALUctrl: 000 add, 001 sub, 010 funct
illegal_op  output  1  one-cycle pulse in DECODE when opcode is unsupported
state  output  4  current state (debug)
instr_count  output  CNT_W  retired instructions, wraps at 2^CNT_W

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=FETCH (0), instr_count=0.
  - PCWrite, Branch, pc_en, MemRead, MemWrite, IRWrite, RegWrite and illegal_op are forced 0 while rst_n is low.
  - All other outputs take their FETCH values.
  - Reset mid-instruction abandons that instruction; it is not counted.
- Outputs are decoded combinationally from state (Moore), except:
  - pc_en, which also depends on zero;
  - handshake-gated strobes, which also depend on mem_ready.
- Outputs not listed for a state are 0.
- State encoding, per-state outputs and transitions:
  - FETCH=0: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00; IRWrite=PCWrite=mem_ready. If mem_ready -> DECODE, else hold in FETCH.
  - DECODE=1: ALUSrcA=0, ALUSrcB=11, ALUOp=000. Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - any other opcode -> FETCH with illegal_op=1
  - MEMADR=2: ALUSrcA=1, ALUSrcB=10, ALUOp=000. lw -> MEMRD, sw -> MEMWR.
    - opcode is sampled from the IR, which is stable from DECODE onward.
  - MEMRD=3: MemRead=1, IorD=1. mem_ready -> MEMWB, else hold.
  - MEMWB=4: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
  - MEMWR=5: MemWrite=1, IorD=1. mem_ready -> FETCH, else hold; MemWrite stays high while waiting.
  - EXEC=6: ALUSrcA=1, ALUSrcB=00, ALUOp=010 -> RTYPEWB.
  - RTYPEWB=7: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
  - BRANCH=8: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01, Branch=1 -> FETCH.
  - ADDIEX=9: ALUSrcA=1, ALUSrcB=10, ALUOp=000 -> ADDIWB.
  - ADDIWB=10: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
  - JUMP=11: PCSource=10, PCWrite=1 -> FETCH.
  - Encodings 12-15 are unreachable; if entered, next state is FETCH and all strobes are 0.
- Instruction latency in cycles, with mem_ready tied high:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- Retirement and instr_count:
  - Increments on the clock edge leaving MEMWB, MEMWR (with mem_ready), RTYPEWB, BRANCH, ADDIWB or JUMP.
  - Does not increment on an illegal opcode.
  - Wraps from 2^CNT_W-1 to 0.
- ALUOp is never 010 outside EXEC, and never 001 outside BRANCH.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with mem_ready=1, then release -> state=0, instr_count=0, all strobes 0 during reset; IRWrite=PCWrite=1 in the first cycle after release.
- R-type: opcode=000000, mem_ready=1 -> states 0,1,6,7,0; ALUOp=010 only in state 6; RegWrite=1 with RegDst=1 in state 7; instr_count=1.
- lw with stall: opcode=100011, mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; MemRead=1 and IorD=1 throughout MEMRD; MemtoReg=1 and RegWrite=1 in state 4.
- beq: opcode=000100 with zero=1 -> pc_en=1, ALUOp=001, PCSource=01 in state 8. Repeat with zero=0 -> pc_en=0. instr_count increments in both cases.
- Illegal opcode and jump: opcode=111111 -> illegal_op pulses for one cycle in state 1, returns to state 0, instr_count unchanged. opcode=000010 -> state 11 with PCWrite=1, PCSource=10.
- Reset mid-operation and wrap: assert rst_n=0 while in MEMWR with mem_ready=0 -> immediately state=0, MemWrite=0. With CNT_W=4, retire 16 addi instructions -> instr_count wraps to 0.
